// File: rtl/prs_pkg.sv
// rtl/prs_pkg.sv - shared constants for the process ready selector
package prs_pkg;

    // Control bit positions in data_in[7:0] of a write
    localparam int PRS_MASK_LO = 0;
    localparam int PRS_MASK_HI = 1;
    localparam int PRS_CLAIM   = 2;
    localparam int PRS_PTR_RST = 3;

    // Field positions in the read word
    localparam int PRS_VLD_BIT = 31;
    localparam int PRS_CNT_LSB = 8;
    localparam int PRS_ID_LSB  = 0;

    localparam int NPROC_MAX = 32;

endpackage

// File: rtl/rr_find_first.sv
// rtl/rr_find_first.sv - round-robin find-first-set starting at ptr
// Ports:
//   req  in  NPROC  request vector (already masked)
//   ptr  in  IDW    index where the scan starts, wrapping at NPROC
//   sel  out IDW    index of the first set bit at or after ptr
//   vld  out 1      any bit of req set
module rr_find_first #(
    parameter int NPROC = 32,
    localparam int IDW  = $clog2(NPROC)
) (
    input  logic [NPROC-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [IDW-1:0]   sel,
    output logic             vld
);

    logic [NPROC-1:0] rot;
    logic [IDW-1:0]   k;

    // Rotate right by ptr so the scan always starts at bit 0; the doubled
    // vector supplies the wrapped-around bits.
    assign rot = NPROC'({req, req} >> ptr);

    // Scan high to low so the lowest set bit is the one that sticks.
    always_comb begin
        k = '0;
        for (int i = NPROC - 1; i >= 0; i--) begin
            if (rot[i]) begin
                k = IDW'(i);
            end
        end
    end

    // Un-rotate; NPROC is a power of two so the IDW-bit add wraps correctly.
    assign sel = ptr + k;
    assign vld = |req;

endmodule

// File: rtl/proc_ready_sel.sv
// rtl/proc_ready_sel.sv - masked round-robin pick over process ready bits
// Optional feature macro: PROC_READY_SEL_IRQ_EN (scheduler interrupt flop).
// Ports:
//   clk       in  1      system clock
//   rst       in  1      asynchronous reset, active low
//   stb       in  1      IO strobe, one cycle per access
//   we        in  1      1 = write, 0 = read
//   data_in   in  32     write word: [7:0] ctrl, [31:16] data
//   data_out  out 32     read word {valid, count, id}, 0 when not reading
//   ack       out 1      equals stb
//   proc_rdy  in  NPROC  level ready bits from process timers
//   irq       out 1      scheduler attention (0 unless the macro is defined)
module proc_ready_sel
    import prs_pkg::*;
#(
    parameter int NPROC = 32,
    localparam int IDW  = $clog2(NPROC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stb,
    input  logic             we,
    input  logic [31:0]      data_in,
    output logic [31:0]      data_out,
    output logic             ack,
    input  logic [NPROC-1:0] proc_rdy,
    output logic             irq
);

    logic [NPROC-1:0] mask, mask_n;
    logic [IDW-1:0]   ptr, ptr_n;
    logic [IDW-1:0]   sel_q;
    logic             vld_q;
    logic [5:0]       cnt_q;

    logic             wr;
    logic             wr_claim;
    logic [NPROC-1:0] req;
    logic [IDW-1:0]   sel;
    logic             vld;
    logic [5:0]       cnt;
    logic [31:0]      rd_word;
    logic             unused_ctrl;

    assign wr       = stb & we;
    assign wr_claim = wr & data_in[PRS_CLAIM];
    assign ack      = stb;
    assign req      = proc_rdy & mask;

    // Upper ctrl bits carry nothing.
    assign unused_ctrl = ^data_in[15:4];

    rr_find_first #(.NPROC(NPROC)) u_find (
        .req (req),
        .ptr (ptr),
        .sel (sel),
        .vld (vld)
    );

    always_comb begin
        cnt = '0;
        for (int i = 0; i < NPROC; i++) begin
            cnt = cnt + 6'(req[i]);
        end
    end

    // Mask bit i is loaded from data_in[16 + i%16]; the lo/hi ctrl bit
    // decides which half takes the write.
    always_comb begin
        mask_n = mask;
        for (int i = 0; i < NPROC; i++) begin
            if ((i < 16 && wr && data_in[PRS_MASK_LO]) ||
                (i >= 16 && wr && data_in[PRS_MASK_HI])) begin
                mask_n[i] = data_in[16 + (i % 16)];
            end
        end
    end

    always_comb begin
        ptr_n = ptr;
        if (wr && data_in[PRS_PTR_RST]) begin
            ptr_n = '0;
        end else if (wr_claim && vld_q) begin
            ptr_n = sel_q + IDW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask  <= '1;
            ptr   <= '0;
            sel_q <= '0;
            vld_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            mask  <= mask_n;
            ptr   <= ptr_n;
            cnt_q <= cnt;
            // A claim hides the pick for one cycle while the scheduler
            // clears the timer, so the old winner is not read twice.
            vld_q <= vld & ~wr_claim;
            if (vld) begin
                sel_q <= sel;
            end
        end
    end

`ifdef PROC_READY_SEL_IRQ_EN
    logic irq_q;
    logic irq_ack_pending;

    // Pending is set by a claim and cleared once vld_q has dropped, so irq
    // re-arms only on a fresh rise of vld_q after the claim.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_q           <= 1'b0;
            irq_ack_pending <= 1'b0;
        end else begin
            if (wr_claim) begin
                irq_ack_pending <= 1'b1;
                irq_q           <= 1'b0;
            end else begin
                if (!vld_q) begin
                    irq_ack_pending <= 1'b0;
                end
                irq_q <= vld_q & ~irq_ack_pending;
            end
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_word                      = '0;
        rd_word[PRS_VLD_BIT]         = vld_q;
        rd_word[PRS_CNT_LSB +: 6]    = cnt_q;
        rd_word[PRS_ID_LSB +: 5]     = 5'(sel_q);
    end

    assign data_out = (stb && !we) ? rd_word : 32'h0;

endmodule

// File: tb/tb_proc_ready_sel.sv
// tb/tb_proc_ready_sel.sv - directed self-checking bench for proc_ready_sel
module tb_proc_ready_sel;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb;
    logic        we;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        ack;
    logic [31:0] proc_rdy;
    logic        irq;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    proc_ready_sel #(.NPROC(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .stb      (stb),
        .we       (we),
        .data_in  (data_in),
        .data_out (data_out),
        .ack      (ack),
        .proc_rdy (proc_rdy),
        .irq      (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] d);
        stb = 1'b1; we = 1'b1; data_in = d;
        tick();
        stb = 1'b0; we = 1'b0; data_in = '0;
    endtask

    task automatic rd(input string tag, input logic [31:0] exp);
        stb = 1'b1; we = 1'b0;
        #1;
        check(tag, data_out, exp);
        check({tag, "_ack"}, {31'b0, ack}, 32'h1);
        stb = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b0; stb = 1'b0; we = 1'b0; data_in = '0; proc_rdy = '0;
        tick(); tick();
        rd("reset_read", 32'h0000_0000);
        check("reset_irq", {31'b0, irq}, 32'h0);
        rst = 1'b1;
        tick();

        // T2: basic pick and claim advancing the pointer
        proc_rdy = 32'h0000_0024;
        tick();
        rd("t2_pick", 32'h8000_0202);
        check("idle_out_zero", data_out, 32'h0);
        wr(32'h0000_0004);
        rd("t2_claim_hidden", 32'h0000_0202);
        tick();
        rd("t2_next_id", 32'h8000_0205);

        // T3: walk ptr to 31, then wrap on claim
        wr(32'h0000_0008);
        proc_rdy = 32'h4000_0000;
        tick();
        rd("t3_id30", 32'h8000_011E);
        wr(32'h0000_0004);
        proc_rdy = 32'h8000_0001;
        tick();
        rd("t3_id31", 32'h8000_021F);
        wr(32'h0000_0004);
        tick();
        rd("t3_wrap_id0", 32'h8000_0200);

        // T4: masking
        wr(32'h0000_0001);
        wr(32'hFFFF_0002);
        proc_rdy = 32'h0001_00FF;
        tick();
        rd("t4_mask_hi", 32'h8000_0110);
        wr(32'h0000_0003);
        tick();
        rd("t4_all_masked", 32'h0000_0010);
        wr(32'hFFFF_0003);

        // T5: claim with ptr reset, then claim while not valid
        proc_rdy = 32'h0000_0080;
        tick();
        rd("t5_id7", 32'h8000_0107);
        wr(32'h0000_000C);
        proc_rdy = 32'h0000_0101;
        tick();
        rd("t5_ptr_rst_wins", 32'h8000_0200);
        proc_rdy = 32'h0000_0000;
        tick();
        rd("t5_empty", 32'h0000_0000);
        wr(32'h0000_0004);
        proc_rdy = 32'h0000_0003;
        tick();
        rd("t5_claim_invalid", 32'h8000_0200);

`ifdef PROC_READY_SEL_IRQ_EN
        // T6: irq rise, drop on claim, re-rise
        proc_rdy = 32'h0;
        tick(); tick();
        check("t6_irq_idle", {31'b0, irq}, 32'h0);
        proc_rdy = 32'h0000_0010;
        tick();
        check("t6_irq_1clk", {31'b0, irq}, 32'h0);
        tick();
        check("t6_irq_rise", {31'b0, irq}, 32'h1);
        wr(32'h0000_0004);
        check("t6_irq_drop", {31'b0, irq}, 32'h0);
        tick();
        check("t6_irq_still_low", {31'b0, irq}, 32'h0);
        tick();
        check("t6_irq_rearm", {31'b0, irq}, 32'h1);
`else
        check("irq_tied_low", {31'b0, irq}, 32'h0);
`endif

        // T1: asynchronous reset mid-run
        wr(32'h0000_0003);
        proc_rdy = 32'h0000_0024;
        tick(); tick();
        #2;
        rst = 1'b0;
        #1;
        rd("t1_async_reset", 32'h0000_0000);
        check("t1_irq", {31'b0, irq}, 32'h0);
        tick();
        rd("t1_held", 32'h0000_0000);
        rst = 1'b1;
        proc_rdy = 32'h8000_0001;
        tick();
        rd("t1_mask_ptr_reset", 32'h8000_0200);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
